digit_rev_agen: RTL and testbench

Parametrised bit/digit-reversal index generator for the NWC/NTT datapath. It is a stream source: on `start` it walks a natural-order counter over N = 2^(RADIX_BITS·l) points and emits each natural index alongside its reversed index over a valid/ready handshake. Reversal is either plain bit reversal or radix-2^RADIX_BITS digit reversal over the active width. It sits ahead of the memory address mapper and feeds the butterfly schedule.

---
 rtl/digit_rev_agen.sv | 165 ++++++++++++++++
 tb/tb_digit_rev_agen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_rev_agen.sv
// digit_rev_agen
// Stream source for the NWC/NTT datapath. After a start it walks a
// natural-order counter over 2^W_eff points. Each beat carries the natural
// index and its reversed index. Reversal is either plain bit reversal over
// W_eff bits, or radix-2^RADIX_BITS digit reversal over l_eff digits.
// All outputs are registered, so the reversal of the *next* index is
// computed one cycle ahead and loaded together with the counter.

module digit_rev_agen #(
  parameter int D_WIDTH    = 16,
  parameter int RADIX_BITS = 2,
  parameter int L_WIDTH    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic [L_WIDTH-1:0] l,
  input  logic               mode,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] idx_nat,
  output logic [D_WIDTH-1:0] idx_rev,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  // Number of whole digits that fit in the index, and a width wide enough
  // to hold any shift amount or effective width from 0 up to D_WIDTH.
  localparam int NDIG = D_WIDTH / RADIX_BITS;
  localparam int SHW  = $clog2(D_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic               r_mode;
  logic [SHW-1:0]     r_lEff;
  logic [SHW-1:0]     r_wEff;

  logic [SHW-1:0]     w_lEffIn;
  logic [SHW-1:0]     w_wEffIn;
  logic [D_WIDTH-1:0] w_nextNat;
  logic [D_WIDTH-1:0] w_bitFull;
  logic [D_WIDTH-1:0] w_digFull;
  logic [D_WIDTH-1:0] w_nextRev;
  logic [D_WIDTH-1:0] w_lastIdx;
  logic               w_nextLast;
  logic               w_handshake;

  // Clamp the requested digit count so the active width never exceeds the
  // index; the clamped width is automatically a multiple of RADIX_BITS.
  always_comb begin
    w_lEffIn = SHW'(l);
    if (int'(l) > NDIG) begin
      w_lEffIn = SHW'(NDIG);
    end
    w_wEffIn = SHW'(int'(w_lEffIn) * RADIX_BITS);
  end

  // Reverse the next counter value across the whole index, then shift the
  // result down so that only the active width (or active digits) remains.
  // Bits above the active width are zero because the counter never
  // reaches them, so the shift leaves zeros in the upper bits.
  always_comb begin
    w_nextNat = idx_nat + 1'b1;
    w_bitFull = '0;
    for (int i = 0; i < D_WIDTH; i++) begin
      w_bitFull[D_WIDTH-1-i] = w_nextNat[i];
    end
    w_digFull = '0;
    for (int j = 0; j < NDIG; j++) begin
      for (int b = 0; b < RADIX_BITS; b++) begin
        w_digFull[(NDIG-1-j)*RADIX_BITS + b] = w_nextNat[j*RADIX_BITS + b];
      end
    end
    if (r_mode) begin
      w_nextRev = w_digFull >> ((SHW'(NDIG) - r_lEff) * RADIX_BITS);
    end else begin
      w_nextRev = w_bitFull >> (SHW'(D_WIDTH) - r_wEff);
    end
  end

  // Final index 2^W_eff - 1, built by shifting an all-ones word so that
  // W_eff = D_WIDTH does not need a wider intermediate.
  always_comb begin
    w_lastIdx   = {D_WIDTH{1'b1}} >> (SHW'(D_WIDTH) - r_wEff);
    w_nextLast  = (w_nextNat == w_lastIdx);
    w_handshake = out_valid && out_ready;
  end

  // Sequencer: clear has priority over everything, start is only honoured
  // in IDLE, and the counter advances only on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mode    <= 1'b0;
      r_lEff    <= '0;
      r_wEff    <= '0;
      out_valid <= 1'b0;
      idx_nat   <= '0;
      idx_rev   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      r_state   <= ST_IDLE;
      out_valid <= 1'b0;
      idx_nat   <= '0;
      idx_rev   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state   <= ST_RUN;
            r_mode    <= mode;
            r_lEff    <= w_lEffIn;
            r_wEff    <= w_wEffIn;
            out_valid <= 1'b1;
            idx_nat   <= '0;
            idx_rev   <= '0;
            out_last  <= (w_wEffIn == '0);
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_handshake) begin
            if (out_last) begin
              r_state   <= ST_DONE;
              out_valid <= 1'b0;
              idx_nat   <= '0;
              idx_rev   <= '0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx_nat  <= w_nextNat;
              idx_rev  <= w_nextRev;
              out_last <= w_nextLast;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_rev_agen.sv
// tb_digit_rev_agen
// Directed bench for digit_rev_agen with default parameters
// (D_WIDTH=16, RADIX_BITS=2, L_WIDTH=5). Expected values are hand-computed.

module tb_digit_rev_agen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear;
  logic [4:0]  l;
  logic        mode;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] idx_nat;
  logic [15:0] idx_rev;
  logic        out_last;
  logic        busy;
  logic        done;

  int checkCount = 0;
  int errorCount = 0;

  // 4-bit bit reversal and 2x2-bit digit reversal of 0..15
  logic [15:0] brTab [16] = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
                              16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};
  logic [15:0] drTab [16] = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd1, 16'd5, 16'd9, 16'd13,
                              16'd2, 16'd6, 16'd10, 16'd14, 16'd3, 16'd7, 16'd11, 16'd15};

  digit_rev_agen #(
    .D_WIDTH(16),
    .RADIX_BITS(2),
    .L_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .clear(clear),
    .l(l),
    .mode(mode),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .idx_nat(idx_nat),
    .idx_rev(idx_rev),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge where beat 0 is visible
  task automatic applyStimulus(input logic [4:0] lVal, input logic modeVal);
    @(negedge clk);
    clear = 1'b0;
    start = 1'b1;
    l     = lVal;
    mode  = modeVal;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run with out_ready high until the last beat is accepted, then check done
  task automatic drainRun(input string tag, input int bound);
    logic sawLast;
    sawLast = 1'b0;
    for (int n = 0; n < bound && !sawLast; n++) begin
      if (out_valid && out_last) sawLast = 1'b1;
      @(negedge clk);
    end
    checkOutput({tag, "_sawlast"}, sawLast, 1);
    checkOutput({tag, "_done"}, done, 1);
  endtask

  // One full 16-point run (l=2); l and mode are scrambled mid-run
  task automatic runSixteen(input logic modeVal);
    logic [15:0] expRev;
    applyStimulus(5'd2, modeVal);
    l    = 5'd3;
    mode = ~modeVal;
    for (int k = 0; k < 16; k++) begin
      expRev = modeVal ? drTab[k] : brTab[k];
      checkOutput("run16_valid", out_valid, 1);
      checkOutput("run16_nat", idx_nat, k);
      checkOutput("run16_rev", idx_rev, expRev);
      checkOutput("run16_last", out_last, (k == 15));
      checkOutput("run16_busy", busy, 1);
      checkOutput("run16_upper", idx_rev[15:4], 0);
      @(negedge clk);
    end
    checkOutput("run16_done", done, 1);
    checkOutput("run16_valid_after", out_valid, 0);
    checkOutput("run16_busy_after", busy, 0);
    @(negedge clk);
    checkOutput("run16_done_pulse", done, 0);
  endtask

  initial begin
    int          expNat;
    logic        stalled;
    logic        finished;
    logic [15:0] prevRev;
    int          beats;

    rst_n     = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    l         = 5'd0;
    mode      = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_nat", idx_nat, 0);
    checkOutput("rst_rev", idx_rev, 0);
    checkOutput("rst_last", out_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_valid", out_valid, 0);

    // Bit reversal, then digit reversal, l=2
    $display("[TB] bit reversal l=2");
    runSixteen(1'b0);
    $display("[TB] digit reversal l=2");
    runSixteen(1'b1);

    // Backpressure over l=3 digit reversal (64 points)
    $display("[TB] backpressure l=3 digit reversal");
    applyStimulus(5'd3, 1'b1);
    expNat   = 0;
    stalled  = 1'b0;
    finished = 1'b0;
    prevRev  = '0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (out_valid) begin
        checkOutput("bp_nat", idx_nat, expNat);
        checkOutput("bp_last", out_last, (expNat == 63));
        checkOutput("bp_upper", idx_rev[15:6], 0);
        if (stalled) checkOutput("bp_hold_rev", idx_rev, prevRev);
        case (expNat)
          1:  checkOutput("bp_rev1", idx_rev, 16);
          6:  checkOutput("bp_rev6", idx_rev, 36);
          27: checkOutput("bp_rev27", idx_rev, 57);
          63: checkOutput("bp_rev63", idx_rev, 63);
          default: ;
        endcase
        prevRev   = idx_rev;
        out_ready = 1'($urandom_range(0, 1));
        stalled   = !out_ready;
        if (out_ready) begin
          if (expNat == 63) finished = 1'b1;
          expNat++;
        end
      end else begin
        checkOutput("bp_valid", out_valid, 1);
        finished = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput("bp_count", expNat, 64);
    checkOutput("bp_done", done, 1);
    out_ready = 1'b1;
    @(negedge clk);

    // clear together with start in the middle of a run
    $display("[TB] clear with start mid-run");
    applyStimulus(5'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("clr_pre_nat", idx_nat, 3);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    checkOutput("clr_valid", out_valid, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_done", done, 0);
    checkOutput("clr_nat", idx_nat, 0);
    checkOutput("clr_rev", idx_rev, 0);
    @(negedge clk);
    checkOutput("clr_nostart", out_valid, 0);
    applyStimulus(5'd2, 1'b1);
    checkOutput("restart_valid", out_valid, 1);
    checkOutput("restart_nat", idx_nat, 0);
    @(negedge clk);
    checkOutput("restart_nat1", idx_nat, 1);
    checkOutput("restart_rev1", idx_rev, 4);
    drainRun("restart", 40);
    @(negedge clk);

    // l=15 clamps to the full 16-bit width
    $display("[TB] l=15 clamped run");
    applyStimulus(5'd15, 1'b0);
    beats    = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 70000 && !finished; cyc++) begin
      if (out_valid) begin
        if (beats == 1) begin
          checkOutput("big_nat1", idx_nat, 1);
          checkOutput("big_rev1", idx_rev, 16'h8000);
          checkOutput("big_last1", out_last, 0);
        end
        if (out_last) begin
          checkOutput("big_last_nat", idx_nat, 16'hFFFF);
          checkOutput("big_last_rev", idx_rev, 16'hFFFF);
          finished = 1'b1;
        end
        beats++;
      end
      @(negedge clk);
    end
    checkOutput("big_beats", beats, 65536);
    checkOutput("big_done", done, 1);
    @(negedge clk);

    // Asynchronous reset mid-run, then l=0 started on the first edge after release
    $display("[TB] reset mid-run and l=0");
    applyStimulus(5'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", out_valid, 0);
    checkOutput("arst_nat", idx_nat, 0);
    checkOutput("arst_rev", idx_rev, 0);
    checkOutput("arst_last", out_last, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rel_busy", busy, 0);
    checkOutput("rel_valid", out_valid, 0);
    start = 1'b1;
    l     = 5'd0;
    mode  = 1'b0;
    @(negedge clk);
    checkOutput("l0_valid", out_valid, 1);
    checkOutput("l0_nat", idx_nat, 0);
    checkOutput("l0_rev", idx_rev, 0);
    checkOutput("l0_last", out_last, 1);
    // start stays high through RUN and DONE and must be ignored there
    @(negedge clk);
    checkOutput("l0_done", done, 1);
    checkOutput("l0_valid_done", out_valid, 0);
    @(negedge clk);
    checkOutput("gap_valid", out_valid, 0);
    checkOutput("gap_done", done, 0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_valid", out_valid, 1);
    checkOutput("b2b_last", out_last, 1);
    drainRun("b2b", 10);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
